// File: rtl/display_share_ctrl_pkg.sv
// Shared constants and arbiter state encoding for the multiplexed
// seven-segment display share controller.
package display_share_ctrl_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int NIBBLE_W        = 4;
  localparam int DEFAULT_CLK_DIV = 100000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/display_share_ctrl_scan_prescaler.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1 and flags the last count
// as the scan tick.
module scan_prescaler
  import display_share_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A one-cycle slot still needs a 1-bit counter that simply stays at 0.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/display_share_ctrl.sv
// Round-robin write arbiter and digit scanner for the shared 4-digit display;
// accepted values are committed only at frame boundaries.
module display_share_ctrl
  import display_share_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     wr_req,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] wr_data0,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] wr_data1,
  output logic [1:0]                     wr_ack,
  input  logic                           blank_lead,
  output logic [NIBBLE_W-1:0]            hex_out,
  output logic [NUM_DIGITS-1:0]          an
);

  // Handshake: a requester holds wr_req[i] until it sees the one-cycle
  // wr_ack[i] pulse; the value it drives is captured on the sampling edge.

  logic                           tick;
  logic                           frame_end;
  logic [1:0]                     idx;
  logic [NUM_DIGITS*NIBBLE_W-1:0] display;
  logic [NUM_DIGITS*NIBBLE_W-1:0] shadow;
  arb_state_e                     state, state_nxt;
  logic                           ptr;
  logic                           winner;
  logic                           grant;
  logic                           commit;
  logic [NUM_DIGITS-1:0]          lead_zero;
  logic                           blanked;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_end = tick && (idx == 2'd3);

  always_comb begin
    winner    = (wr_req == 2'b11) ? ptr : wr_req[1];
    grant     = (state == IDLE) && (wr_req != 2'b00);
    commit    = (state == PEND) && frame_end;
    state_nxt = state;
    if (grant) begin
      state_nxt = PEND;
    end else if (commit) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      display <= '0;
      shadow  <= '0;
      ptr     <= 1'b0;
      wr_ack  <= 2'b00;
    end else begin
      state  <= state_nxt;
      wr_ack <= 2'b00;
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (grant) begin
        shadow <= winner ? wr_data1 : wr_data0;
        ptr    <= ~winner;
        wr_ack <= winner ? 2'b10 : 2'b01;
      end
      if (commit) begin
        display <= shadow;
      end
    end
  end

  // lead_zero[i] is set when nibbles i..top are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (display[NIBBLE_W*(NUM_DIGITS-1) +: NIBBLE_W] == '0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (display[NIBBLE_W*i +: NIBBLE_W] == '0);
    end
    blanked = blank_lead && (idx != 2'd0) && lead_zero[idx];
    hex_out = display[{idx, 2'b00} +: NIBBLE_W];
    an      = blanked ? 4'b1111 : ~(4'b0001 << idx);
  end

endmodule

// File: tb/tb_display_share_ctrl.sv
// Bench for display_share_ctrl: cycle-level model plus directed vectors
// on a CLK_DIV=4 instance and a CLK_DIV=1 instance.
module tb_display_share_ctrl;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [1:0]  wr_req;
  logic [15:0] wr_data0, wr_data1;
  logic [1:0]  wr_ack;
  logic        blank_lead;
  logic [3:0]  hex_out;
  logic [3:0]  an;

  logic [1:0]  wr_req_d1;
  logic [15:0] wr_data_d1;
  logic [1:0]  wr_ack_d1;
  logic [3:0]  hex_out_d1;
  logic [3:0]  an_d1;

  int checks = 0;
  int errors = 0;

  assign wr_req = {req1, req0};

  display_share_ctrl #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_data0   (wr_data0),
    .wr_data1   (wr_data1),
    .wr_ack     (wr_ack),
    .blank_lead (blank_lead),
    .hex_out    (hex_out),
    .an         (an)
  );

  display_share_ctrl #(.CLK_DIV(1)) dut_div1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req_d1),
    .wr_data0   (wr_data_d1),
    .wr_data1   (wr_data_d1),
    .wr_ack     (wr_ack_d1),
    .blank_lead (1'b0),
    .hex_out    (hex_out_d1),
    .an         (an_d1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Model: t counts cycles since reset release; the slot, frame boundary and
  // display contents follow from t and the requests seen so far.
  int          t;
  logic [15:0] m_disp;
  logic        m_pend;
  logic [15:0] m_val;
  logic        m_ptr;
  logic [1:0]  m_ack;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; m_disp = '0; m_pend = 1'b0; m_val = '0; m_ptr = 1'b0; m_ack = 2'b00;
    end else begin
      logic fe;
      logic w;
      fe    = (t % (4 * DIV)) == (4 * DIV - 1);
      m_ack = 2'b00;
      if (!m_pend) begin
        if (wr_req != 2'b00) begin
          w        = (wr_req == 2'b11) ? m_ptr : wr_req[1];
          m_val    = w ? wr_data1 : wr_data0;
          m_ack[w] = 1'b1;
          m_ptr    = ~w;
          m_pend   = 1'b1;
        end
      end else if (fe) begin
        m_disp = m_val;
        m_pend = 1'b0;
      end
      t++;
    end
  end

  function automatic logic [3:0] exp_an(input int slot, input logic [15:0] disp, input logic bl);
    logic [15:0] upper;
    upper = disp >> (4 * slot);
    if (bl && slot != 0 && upper == 16'h0) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Scoreboard compare, every cycle, away from the active edge
  always begin
    int slot, slot1;
    logic [15:0] hexv;
    @(posedge clk);
    #1;
    slot  = (t / DIV) % 4;
    slot1 = t % 4;
    hexv  = (m_disp >> (4 * slot)) & 16'hF;
    check("cyc_hex", {12'h0, hex_out}, hexv);
    check("cyc_an", {12'h0, an}, {12'h0, exp_an(slot, m_disp, blank_lead)});
    check("cyc_ack", {14'h0, wr_ack}, {14'h0, m_ack});
    check("cyc_an_div1", {12'h0, an_d1}, {12'h0, exp_an(slot1, 16'h0, 1'b0)});
    check("cyc_hex_div1", {12'h0, hex_out_d1}, 16'h0);
    check("cyc_ack_div1", {14'h0, wr_ack_d1}, 16'h0);
  end

  // Driver tasks
  task automatic wait_slot_start(input int s);
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      #1;
      if ((t % DIV) == 0 && ((t / DIV) % 4) == s) return;
    end
    checks++;
    errors++;
    $display("FAIL slot_wait: slot %0d start not reached within 64 cycles", s);
  endtask

  task automatic write_req(input int r, input logic [15:0] d, input int budget, output int lat);
    lat = -1;
    if (r == 0) begin wr_data0 = d; req0 = 1'b1; end
    else        begin wr_data1 = d; req1 = 1'b1; end
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (wr_ack[r]) begin lat = n; break; end
    end
    #2;
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_r%0d: got no ack in %0d cycles, required one", r, budget);
    end
  endtask

  logic [3:0] an_seq   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] an_blank [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
  logic [3:0] hex_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] an_0050  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  logic [3:0] hex_0050 [4] = '{4'h0, 4'h5, 4'h0, 4'h0};

  initial begin
    int lat, lat0, lat1;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
    blank_lead = 1'b0; wr_req_d1 = 2'b00; wr_data_d1 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {12'h0, an}, 16'h000E);
    check("rst_hex", {12'h0, hex_out}, 16'h0);
    check("rst_ack", {14'h0, wr_ack}, 16'h0);
    check("rst_an_div1", {12'h0, an_d1}, 16'h000E);
    #2 rst_n = 1'b1;

    // 1: idle scan
    for (int s = 0; s < 4; s++) begin
      wait_slot_start(s);
      check("scan_an", {12'h0, an}, {12'h0, an_seq[s]});
      check("scan_hex", {12'h0, hex_out}, 16'h0);
    end

    // 2: blanking of an all-zero display
    #2 blank_lead = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_slot_start(s);
      check("blank_zero_an", {12'h0, an}, {12'h0, an_blank[s]});
    end
    #2 blank_lead = 1'b0;

    // 3: single write, committed on the next frame
    wait_slot_start(0);
    #2;
    write_req(0, 16'h1234, 8, lat);
    check("w1234_latency", lat[15:0], 16'd1);
    check("w1234_not_yet", {12'h0, hex_out}, 16'h0);
    for (int s = 0; s < 4; s++) begin
      wait_slot_start(s);
      check("w1234_hex", {12'h0, hex_out}, {12'h0, hex_1234[s]});
    end

    // 4: both requesting from reset, round robin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    fork
      write_req(0, 16'hAAAA, 8, lat0);
      write_req(1, 16'h5555, 64, lat1);
    join
    check("rr_first_latency", lat0[15:0], 16'd1);
    check("rr_second_waits", {15'h0, lat1 > 1}, 16'd1);
    check("rr_shows_aaaa", {12'h0, hex_out}, 16'h000A);
    wait_slot_start(0);
    check("rr_5555_slot0", {12'h0, hex_out}, 16'h0005);
    wait_slot_start(3);
    check("rr_5555_slot3", {12'h0, hex_out}, 16'h0005);

    // 5: leading-zero blanking on 0050
    #2 blank_lead = 1'b1;
    write_req(0, 16'h0050, 8, lat);
    for (int s = 0; s < 4; s++) begin
      wait_slot_start(s);
      check("b0050_an", {12'h0, an}, {12'h0, an_0050[s]});
      check("b0050_hex", {12'h0, hex_out}, {12'h0, hex_0050[s]});
    end
    #2 blank_lead = 1'b0;

    // 6: reset during PEND discards the pending value
    wait_slot_start(0);
    #2;
    write_req(1, 16'hBEEF, 8, lat);
    rst_n = 1'b0;
    #1;
    check("midrst_an", {12'h0, an}, 16'h000E);
    check("midrst_hex", {12'h0, hex_out}, 16'h0);
    check("midrst_ack", {14'h0, wr_ack}, 16'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_slot_start(s);
      check("midrst_no_beef", {12'h0, hex_out}, 16'h0);
    end
    repeat (20) @(posedge clk);
    #1;

    // CLK_DIV=1: anode advances every cycle
    for (int n = 0; n < 8; n++) begin
      if ((t % 4) == 0) break;
      @(posedge clk);
      #1;
    end
    for (int s = 0; s < 4; s++) begin
      check("div1_an", {12'h0, an_d1}, {12'h0, an_seq[s]});
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
